// File: rtl/serial_adder_seq.sv
// serial_adder_seq
//   Multi-cycle adder/subtractor. Processes WIDTH-bit operands DIGIT bits
//   per clock with a registered carry, so one operation takes N = WIDTH/DIGIT
//   RUN cycles plus one DONE cycle.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only when not busy (IDLE or DONE)
//   a, b      operands, captured on an accepted start
//   cin       carry-in (add) / borrow-in (sub), captured on an accepted start
//   sub       0: a+b+cin, 1: a-b-cin, captured on an accepted start
//   busy      operation in progress
//   done      one-cycle pulse, results valid
//   sum       result (mod 2^WIDTH), held until the next completion
//   cout      raw carry out of the MSB (for sub: 1 = no borrow)
//   overflow  two's-complement signed overflow
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_shift;

  // Ripple-add the low digit. dig_cmsb is the carry into the top bit of the
  // digit; on the last digit that is the carry into the operand MSB.
  always_comb begin : digit_add
    logic c;
    c        = carry_q;
    dig_sum  = '0;
    dig_cmsb = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dig_cmsb   = c;
      dig_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    dig_cout = c;
  end

  // New digit enters from the MSB end so that after N digits the result
  // register holds the full word in its natural bit order.
  always_comb begin
    res_shift = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        busy_d  = 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_shift;
          cout_d  = dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
        end
      end

      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          // Subtraction as a + ~b + 1: inverting b and the carry-in turns a
          // borrow-in of 1 into a carry-in of 0.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq.
//   u_dut8  : WIDTH=8,  DIGIT=1 - directed vectors, handshake, reset, random
//   u_dut16 : WIDTH=16, DIGIT=4 - corner vector plus random operations
//   u_w4*   : WIDTH=4,  DIGIT=1/2/4 - exhaustive operand sweep
module tb_serial_adder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic       start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4 [3];
  logic       done4 [3];
  logic       cout4 [3];
  logic       ovf4  [3];
  logic [3:0] sum4  [3];

  serial_adder_seq #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));

  serial_adder_seq #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16));

  serial_adder_seq #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4[0]), .done(done4[0]), .sum(sum4[0]), .cout(cout4[0]), .overflow(ovf4[0]));

  serial_adder_seq #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4[1]), .done(done4[1]), .sum(sum4[1]), .cout(cout4[1]), .overflow(ovf4[1]));

  serial_adder_seq #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4[2]), .done(done4[2]), .sum(sum4[2]), .cout(cout4[2]), .overflow(ovf4[2]));

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Arithmetic reference: returns {overflow, cout, sum[15:0]} for width w.
  function automatic logic [17:0] ref_op(int w, logic [15:0] op_a, logic [15:0] op_b,
                                         logic ci, logic is_sub);
    int lim, ua, ub, sa, sb, c, t, s;
    logic co, ov;
    logic [15:0] r;
    lim = 1 << (w - 1);
    ua  = int'(op_a) & (2 * lim - 1);
    ub  = int'(op_b) & (2 * lim - 1);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    c   = ci ? 1 : 0;
    if (!is_sub) begin
      t  = ua + ub + c;
      co = (t >= 2 * lim);
      s  = sa + sb + c;
    end else begin
      t  = ua - ub - c;
      co = (ua >= ub + c);
      s  = sa - sb - c;
    end
    ov = (s >= lim) || (s < -lim);
    r  = 16'(t & (2 * lim - 1));
    return {ov, co, r};
  endfunction

  // Cycle model for the 8-bit unit: a countdown of RUN cycles after each
  // accepted start, with the arithmetic result published when it expires.
  int          m_cnt  = 0;
  logic        m_done = 1'b0;
  logic [17:0] m_res  = '0;
  logic [17:0] m_pend = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_done = (m_cnt == 0);
      if (m_done) m_res = m_pend;
    end else begin
      m_done = 1'b0;
      if (start8) begin
        m_pend = ref_op(8, {8'h00, a8}, {8'h00, b8}, cin8, sub8);
        m_cnt  = 8;
      end
    end
    #1;
    check("cycle8{busy,done,cout,ovf,sum}", {busy8, done8, cout8, ovf8, sum8},
          {m_cnt > 0, m_done, m_res[16], m_res[17], m_res[7:0]});
  end

  task automatic wait_done8(output bit ok);
    int n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = done8;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tci, input logic tsub,
                     input logic [7:0] es, input logic ec, input logic eo, input string nm);
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tci; sub8 = tsub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    lat = 1; bcnt = 0; seen = 0;
    while (!seen && lat < 20) begin
      if (busy8) bcnt++;
      if (done8) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({nm, "_done_seen"}, 32'(seen), 1);
    check({nm, "_latency"}, lat, 9);
    check({nm, "_busy_cycles"}, bcnt, 8);
    check({nm, "_result{cout,ovf,sum}"}, {cout8, ovf8, sum8}, {ec, eo, es});
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                      input logic tsub, input logic [17:0] exp, input string nm);
    int lat;
    @(negedge clk);
    a16 = ta; b16 = tb; cin16 = tci; sub16 = tsub; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1;
    while (!done16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_done_seen"}, 32'(done16), 1);
    check({nm, "_latency"}, lat, 5);
    check({nm, "_result{ovf,cout,sum}"}, {ovf16, cout16, sum16}, exp);
  endtask

  initial begin
    bit ok;
    int hold_bad, spurious;
    logic [17:0] e16;
    logic [15:0] r1, r2;
    logic rc, rs;

    repeat (3) @(negedge clk);
    check("reset_state8", {busy8, done8, cout8, ovf8, sum8}, 0);
    check("reset_state16", {busy16, done16, cout16, ovf16, sum16}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Hand-computed vectors
    op8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
    op8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_00_c1");
    op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "add_80_80");
    op8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, "sub_10_01");
    op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    op8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_00_01");

    // start during RUN is ignored
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'h70; b8 = 8'h70; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(ok);
    check("ignore_done_seen", 32'(ok), 1);
    check("ignore_result", {cout8, ovf8, sum8}, {1'b0, 1'b0, 8'h33});
    @(negedge clk);
    check("ignore_no_second_op", 32'(busy8), 0);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(ok);
    check("b2b_first_done", 32'(ok), 1);
    check("b2b_first_sum", sum8, 8'h02);
    a8 = 8'h40; b8 = 8'h05; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_no_bubble_busy", 32'(busy8), 1);
    hold_bad = 0;
    for (int n = 0; n < 20 && !done8; n++) begin
      if (sum8 !== 8'h02) hold_bad++;
      @(negedge clk);
    end
    check("b2b_sum_held", hold_bad, 0);
    check("b2b_second_done", 32'(done8), 1);
    check("b2b_second_sum", sum8, 8'h45);

    // asynchronous reset mid-operation
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async{busy,done,sum}", {busy8, done8, sum8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) spurious++;
    end
    check("rst_no_done_after", spurious, 0);
    op8(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "post_reset_add");

    // randomized traffic, checked every cycle by the model process
    repeat (3000) begin
      @(negedge clk);
      start8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=16, DIGIT=4
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}, "w16_ffff_0001");
    repeat (20) begin
      r1 = 16'($urandom); r2 = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      e16 = ref_op(16, r1, r2, rc, rs);
      op16(r1, r2, rc, rs, e16, "w16_rand");
    end

    // WIDTH=4 exhaustive, DIGIT=1/2/4 in parallel
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            logic [17:0] e4;
            bit seen [3];
            int exp_lat [3];
            int n;
            exp_lat = '{5, 3, 2};
            seen = '{0, 0, 0};
            e4 = ref_op(4, 16'(ia), 16'(ib), ic[0], is[0]);
            @(negedge clk);
            a4 = 4'(ia); b4 = 4'(ib); cin4 = ic[0]; sub4 = is[0]; start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            n = 1;
            while (1) begin
              for (int k = 0; k < 3; k++) begin
                if (!seen[k] && done4[k]) begin
                  seen[k] = 1;
                  check($sformatf("w4_d%0d_result_%0h_%0h_%0d_%0d", 1 << k, ia, ib, ic, is),
                        {ovf4[k], cout4[k], sum4[k]}, {e4[17], e4[16], e4[3:0]});
                  check($sformatf("w4_d%0d_latency", 1 << k), n, exp_lat[k]);
                end
              end
              if ((seen[0] && seen[1] && seen[2]) || n >= 10) break;
              @(negedge clk);
              n++;
            end
            for (int k = 0; k < 3; k++)
              check($sformatf("w4_d%0d_done_seen", 1 << k), 32'(seen[k]), 1);
          end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
